// File: rtl/mem_bus_responder.sv
// Memory-side responder for the control unit's MAR/MDR strobes: captures one request,
// services it against an internal byte-wide RAM (little-endian words) and returns rdy.
module mem_bus_responder #(
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          M_clk,
    input  logic          MRD,
    input  logic          MWR,
    input  logic          W_B,
    input  logic [AW-1:0] abus,
    input  logic [15:0]   dbus_in,
    output logic [15:0]   dbus_out,
    output logic          dbus_oe,
    output logic          busy,
    output logic          rdy,
    output logic          err
);

    // state  | meaning
    // S_IDLE | waiting for a qualified request; rdy/err pulses are visible here
    // S_WAIT | wait-state down-counter running
    // S_LO   | access byte at addr (low data byte)
    // S_HI   | access byte at addr+1 (high data byte, word only)
    // S_DONE | access finished; rdy and dbus_oe registered on the way back to idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t        state_q;
    logic [3:0]    wait_cnt_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   data_q;
    logic          word_q;
    logic          rd_q;
    logic [15:0]   dbus_out_q;
    logic          dbus_oe_q;
    logic          busy_q;
    logic          rdy_q;
    logic          err_q;

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    always_comb begin
        mem_addr  = (state_q == S_HI) ? (addr_q + AW'(1)) : addr_q;
        mem_wdata = (state_q == S_HI) ? data_q[15:8] : data_q[7:0];
        // Gating with rst keeps a reset that lands on an access cycle from writing.
        mem_we    = !rst && !rd_q && ((state_q == S_LO) || (state_q == S_HI));
        mem_rdata = mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            word_q     <= 1'b0;
            rd_q       <= 1'b0;
            dbus_out_q <= '0;
            dbus_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (M_clk && (MRD ^ MWR)) begin
                        addr_q     <= abus;
                        data_q     <= dbus_in;
                        word_q     <= W_B;
                        rd_q       <= MRD;
                        busy_q     <= 1'b1;
                        dbus_oe_q  <= 1'b0;
                        wait_cnt_q <= WAIT_INIT;
                        state_q    <= (WAIT_CYCLES > 0) ? S_WAIT : S_LO;
                    end else if (M_clk && MRD && MWR) begin
                        err_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= S_LO;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                S_LO: begin
                    if (rd_q) begin
                        dbus_out_q <= {8'h00, mem_rdata};
                    end
                    state_q <= word_q ? S_HI : S_DONE;
                end
                S_HI: begin
                    if (rd_q) begin
                        dbus_out_q[15:8] <= mem_rdata;
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    rdy_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    dbus_oe_q <= rd_q;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dbus_out = dbus_out_q;
    assign dbus_oe  = dbus_oe_q;
    assign busy     = busy_q;
    assign rdy      = rdy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: one instance with one wait state (a) and one
// with none (b); expected values are hand-computed constants.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mclk_a = 1'b0;
    logic        mclk_b = 1'b0;
    logic        MRD = 1'b0;
    logic        MWR = 1'b0;
    logic        W_B = 1'b0;
    logic [7:0]  abus = 8'h00;
    logic [15:0] dbus_in = 16'h0000;

    logic [15:0] dout_a, dout_b;
    logic        oe_a, oe_b, busy_a, busy_b, rdy_a, rdy_b, err_a, err_b;

    int n_asserts = 0;
    int n_fails   = 0;
    int lat;
    int n_rdy;

    always #5 clk = ~clk;

    mem_bus_responder #(.AW(8), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .M_clk(mclk_a), .MRD(MRD), .MWR(MWR), .W_B(W_B),
        .abus(abus), .dbus_in(dbus_in), .dbus_out(dout_a), .dbus_oe(oe_a),
        .busy(busy_a), .rdy(rdy_a), .err(err_a)
    );

    mem_bus_responder #(.AW(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .M_clk(mclk_b), .MRD(MRD), .MWR(MWR), .W_B(W_B),
        .abus(abus), .dbus_in(dbus_in), .dbus_out(dout_b), .dbus_oe(oe_b),
        .busy(busy_b), .rdy(rdy_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one clock; returns #1 after the capture edge.
    task automatic issue(input bit sel, input logic rd, input logic wr, input logic wb,
                         input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        MRD = rd; MWR = wr; W_B = wb; abus = a; dbus_in = d;
        if (sel) mclk_b = 1'b1; else mclk_a = 1'b1;
        @(posedge clk);
        #1;
        mclk_a = 1'b0; mclk_b = 1'b0; MRD = 1'b0; MWR = 1'b0;
        abus = ~a; dbus_in = ~d;
    endtask

    // Edges after the capture edge until rdy is seen; 99 if it never comes.
    task automatic wait_rdy(input bit sel, output int l);
        l = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if ((sel ? rdy_b : rdy_a) === 1'b1) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic xfer(input string tag, input bit sel, input logic rd, input logic wb,
                        input logic [7:0] a, input logic [15:0] d, input int exp_lat);
        int l;
        issue(sel, rd, !rd, wb, a, d);
        wait_rdy(sel, l);
        check(tag, l, exp_lat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset dbus_out", dout_a, 16'h0000);
        check("reset dbus_oe", oe_a, 1'b0);
        check("reset busy", busy_a, 1'b0);
        check("reset rdy", rdy_a, 1'b0);
        check("reset err", err_a, 1'b0);
        rst = 1'b0;

        // Word write / word read, one wait state
        issue(0, 1'b0, 1'b1, 1'b1, 8'h10, 16'hBEEF);
        check("busy after capture", busy_a, 1'b1);
        wait_rdy(0, lat);
        check("word write latency", lat, 4);
        check("busy at rdy", busy_a, 1'b0);
        check("oe after write", oe_a, 1'b0);
        @(posedge clk); #1;
        check("rdy one cycle", rdy_a, 1'b0);

        xfer("word read latency", 0, 1'b1, 1'b1, 8'h10, 16'h0000, 4);
        check("word read data", dout_a, 16'hBEEF);
        check("word read oe", oe_a, 1'b1);
        repeat (2) @(posedge clk); #1;
        check("oe held", oe_a, 1'b1);
        check("dout held", dout_a, 16'hBEEF);

        issue(0, 1'b1, 1'b0, 1'b0, 8'h11, 16'h0000);
        check("oe drops on accept", oe_a, 1'b0);
        check("dout kept on accept", dout_a, 16'hBEEF);
        wait_rdy(0, lat);
        check("byte read latency", lat, 3);
        check("byte read @11", dout_a, 16'h00BE);

        // Byte write over a word
        xfer("word write 1234", 0, 1'b0, 1'b1, 8'h20, 16'h1234, 4);
        xfer("byte write latency", 0, 1'b0, 1'b0, 8'h21, 16'hFF5A, 3);
        xfer("word read @20 lat", 0, 1'b1, 1'b1, 8'h20, 16'h0000, 4);
        check("merged word", dout_a, 16'h5A34);

        // Word wrap across the top of the address space
        xfer("word write @FF", 0, 1'b0, 1'b1, 8'hFF, 16'hA1B2, 4);
        xfer("byte read @FF lat", 0, 1'b1, 1'b0, 8'hFF, 16'h0000, 3);
        check("byte @FF", dout_a, 16'h00B2);
        xfer("byte read @00 lat", 0, 1'b1, 1'b0, 8'h00, 16'h0000, 3);
        check("byte @00 wrapped", dout_a, 16'h00A1);

        // Read and write together: error pulse, no access
        issue(0, 1'b1, 1'b1, 1'b1, 8'h10, 16'hFFFF);
        check("err pulse", err_a, 1'b1);
        check("busy on err", busy_a, 1'b0);
        @(posedge clk); #1;
        check("err one cycle", err_a, 1'b0);
        xfer("read after err lat", 0, 1'b1, 1'b1, 8'h10, 16'h0000, 4);
        check("ram unchanged by err", dout_a, 16'hBEEF);

        // Second request while busy is ignored
        issue(0, 1'b1, 1'b0, 1'b1, 8'h20, 16'h0000);
        @(negedge clk);
        MWR = 1'b1; W_B = 1'b1; abus = 8'h20; dbus_in = 16'h0000; mclk_a = 1'b1;
        @(posedge clk); #1;
        mclk_a = 1'b0; MWR = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rdy_a === 1'b1) n_rdy++;
        end
        check("single rdy while busy", n_rdy, 1);
        check("busy request data", dout_a, 16'h5A34);
        xfer("read after ignored lat", 0, 1'b1, 1'b1, 8'h20, 16'h0000, 4);
        check("ignored write not done", dout_a, 16'h5A34);

        // Reset during the high byte of a word write
        xfer("clear @40", 0, 1'b0, 1'b1, 8'h40, 16'h0000, 4);
        issue(0, 1'b0, 1'b1, 1'b1, 8'h40, 16'hCCDD);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("busy after abort", busy_a, 1'b0);
        check("oe after abort", oe_a, 1'b0);
        rst = 1'b0;
        xfer("byte read @40 lat", 0, 1'b1, 1'b0, 8'h40, 16'h0000, 3);
        check("low byte kept", dout_a, 16'h00DD);
        xfer("word read @40 lat", 0, 1'b1, 1'b1, 8'h40, 16'h0000, 4);
        check("high byte not written", dout_a, 16'h00DD);

        // No wait states, back-to-back requests
        xfer("b byte write lat", 1, 1'b0, 1'b0, 8'h05, 16'h0077, 2);
        xfer("b byte read lat", 1, 1'b1, 1'b0, 8'h05, 16'h0000, 2);
        check("b byte read data", dout_b, 16'h0077);
        check("b oe", oe_b, 1'b1);
        xfer("b word write lat", 1, 1'b0, 1'b1, 8'h06, 16'h0102, 3);
        xfer("b word read lat", 1, 1'b1, 1'b1, 8'h06, 16'h0000, 3);
        check("b word read data", dout_b, 16'h0102);
        xfer("b word read @05 lat", 1, 1'b1, 1'b1, 8'h05, 16'h0000, 3);
        check("b word read @05", dout_b, 16'h0277);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
